// File: rtl/alu_wb_pkg.sv
// Shared opcode/funct3 constants and FSM state encoding for the write-back block.
package alu_wb_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_WRITE    = 2'd2
  } state_t;

  // Opcodes whose result comes straight from the ALU and is written one cycle after accept.
  function automatic logic is_alu_class(input logic [6:0] opc);
    return (opc == OPC_OP) || (opc == OPC_OP_IMM) || (opc == OPC_LUI) ||
           (opc == OPC_AUIPC) || (opc == OPC_JAL) || (opc == OPC_JALR);
  endfunction

  // Only arithmetic/logic results update the carry/zero flags.
  function automatic logic is_flag_class(input logic [6:0] opc);
    return (opc == OPC_OP) || (opc == OPC_OP_IMM);
  endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational load formatter: selects byte/half/word from the aligned load word,
// sign/zero extends it, and flags misaligned or reserved load types.
module load_extract
  import alu_wb_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [DWIDTH-1:0] rdata,
  input  logic [2:0]        funct3,
  input  logic [1:0]        offset,
  output logic [DWIDTH-1:0] data,
  output logic              bad
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection from the byte offset; halves use only offset[1].
  always_comb begin
    byte_sel = rdata[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  // Extension by load type; misaligned halves/words and reserved funct3 are rejected.
  always_comb begin
    data = '0;
    bad  = 1'b0;
    case (funct3)
      F3_LB:  data = {{(DWIDTH-8){byte_sel[7]}}, byte_sel};
      F3_LBU: data = {{(DWIDTH-8){1'b0}}, byte_sel};
      F3_LH: begin
        data = {{(DWIDTH-16){half_sel[15]}}, half_sel};
        bad  = offset[0];
      end
      F3_LHU: begin
        data = {{(DWIDTH-16){1'b0}}, half_sel};
        bad  = offset[0];
      end
      F3_LW: begin
        data = rdata;
        bad  = (offset != 2'b00);
      end
      default: bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_writeback.sv
// Write-back stage: accepts one retiring instruction with its ALU result, waits for load
// data when needed, and issues a single register-file write per instruction.
//
// Handshake: an instruction is taken on a rising edge where in_valid && in_ready. in_ready
// is high only in IDLE; in_valid may be held, and is ignored while in_ready is low.
module alu_writeback
  import alu_wb_pkg::*;
#(
  parameter int DWIDTH  = 32,
  parameter int AWIDTH  = 5,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [DWIDTH:0]   alu_result,
  input  logic              mem_rvalid,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              rf_we,
  output logic [AWIDTH-1:0] rf_waddr,
  output logic [DWIDTH-1:0] rf_wdata,
  output logic              carry_flag,
  output logic              zero_flag,
  output logic              wb_err,
  output state_t            dbg_state
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t            state, state_d;
  logic [CW-1:0]     cnt;
  logic [AWIDTH-1:0] rd_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic              accept;
  logic [6:0]        opc;
  logic [AWIDTH-1:0] rd_in;
  logic              alu_take, ld_take, ld_done, err_set;
  logic [DWIDTH-1:0] ld_data;
  logic              ld_bad;
  logic              unused_bits;

  assign opc         = instr[6:0];
  assign rd_in       = instr[7 +: AWIDTH];
  assign in_ready    = (state == ST_IDLE);
  assign accept      = in_valid && in_ready;
  assign dbg_state   = state;
  assign unused_bits = ^{instr[31:15]};

  load_extract #(.DWIDTH(DWIDTH)) u_load_extract (
    .rdata  (mem_rdata),
    .funct3 (f3_q),
    .offset (off_q),
    .data   (ld_data),
    .bad    (ld_bad)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  // Next-state and datapath control strobes.
  always_comb begin
    state_d  = state;
    alu_take = 1'b0;
    ld_take  = 1'b0;
    ld_done  = 1'b0;
    err_set  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (is_alu_class(opc)) begin
            alu_take = 1'b1;
            state_d  = ST_WRITE;
          end else if (opc == OPC_LOAD) begin
            ld_take = 1'b1;
            state_d = ST_WAIT_MEM;
          end
        end
      end
      ST_WAIT_MEM: begin
        // Arriving data takes priority over the timeout in the same cycle.
        if (mem_rvalid) begin
          if (ld_bad) begin
            err_set = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ld_done = 1'b1;
            state_d = ST_WRITE;
          end
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          err_set = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Cycles spent in WAIT_MEM; zero whenever not waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   cnt <= '0;
    else if (state == ST_WAIT_MEM) cnt <= cnt + 1'b1;
    else                          cnt <= '0;
  end

  // Pending load context, captured at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      f3_q  <= '0;
      off_q <= '0;
    end else if (ld_take) begin
      rd_q  <= rd_in;
      f3_q  <= instr[14:12];
      off_q <= alu_result[1:0];
    end
  end

  // Write port, flags and error pulse; address/data only move on a real write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
      wb_err     <= 1'b0;
    end else begin
      rf_we  <= 1'b0;
      wb_err <= err_set;
      if (alu_take) begin
        if (rd_in != '0) begin
          rf_we    <= 1'b1;
          rf_waddr <= rd_in;
          rf_wdata <= alu_result[DWIDTH-1:0];
        end
        if (is_flag_class(opc)) begin
          carry_flag <= alu_result[DWIDTH];
          zero_flag  <= (alu_result[DWIDTH-1:0] == '0);
        end
      end
      if (ld_done && (rd_q != '0)) begin
        rf_we    <= 1'b1;
        rf_waddr <= rd_q;
        rf_wdata <= ld_data;
      end
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: hand-computed vectors plus a write scoreboard.
module tb_alu_writeback;
  import alu_wb_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int TO = 16;

  logic          clk, rst_n;
  logic          in_valid, in_ready;
  logic [31:0]   instr;
  logic [DW:0]   alu_result;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          carry_flag, zero_flag, wb_err;
  state_t        dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [AW+DW-1:0] exp_q[$];

  alu_writeback #(.DWIDTH(DW), .AWIDTH(AW), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instr      (instr),
    .alu_result (alu_result),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .wb_err     (wb_err),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Scoreboard: every register write must match the next expected {waddr, wdata}.
  always @(negedge clk) begin
    if (rst_n && rf_we) begin
      check("sb_write_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) check("sb_write", 64'({rf_waddr, rf_wdata}), 64'(exp_q.pop_front()));
    end
  end

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [4:0] rd,
                                     input logic [2:0] f3);
    return {17'd0, f3, rd, opc};
  endfunction

  // Drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [DW:0] alu);
    in_valid   = 1'b1;
    instr      = ins;
    alu_result = alu;
    tick();
    in_valid   = 1'b0;
  endtask

  task automatic mem_return(input logic [DW-1:0] data);
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    tick();
    mem_rvalid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; instr = '0; alu_result = '0;
    mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("rst_outputs", 64'({rf_we, rf_waddr, rf_wdata, carry_flag, zero_flag, wb_err}), 64'(0));

    // 1: reset during WAIT_MEM drops the load; a late rvalid is ignored
    send(mk(OPC_LOAD, 5'd7, F3_LW), 33'h0_0000_0100);
    check("t1_wait_state", 64'(dbg_state), 64'(ST_WAIT_MEM));
    check("t1_busy", 64'(in_ready), 64'(0));
    rst_n = 1'b0;
    #2;
    check("t1_rst_outputs", 64'({rf_we, rf_waddr, rf_wdata, carry_flag, zero_flag, wb_err}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("t1_ready_after", 64'(in_ready), 64'(1));
    mem_return(32'h1234_5678);
    check("t1_late_rvalid", 64'({rf_we, wb_err}), 64'(0));
    check("t1_state_idle", 64'(dbg_state), 64'(ST_IDLE));

    // 2: ADD with carry-out and zero result
    exp_q.push_back({5'd5, 32'h0000_0000});
    send(mk(OPC_OP, 5'd5, 3'b000), 33'h1_0000_0000);
    check("t2_we", 64'(rf_we), 64'(1));
    check("t2_waddr", 64'(rf_waddr), 64'(5));
    check("t2_wdata", 64'(rf_wdata), 64'(0));
    check("t2_flags", 64'({carry_flag, zero_flag}), 64'(2'b11));
    check("t2_not_ready", 64'(in_ready), 64'(0));
    tick();
    check("t2_we_pulse", 64'(rf_we), 64'(0));
    check("t2_ready_again", 64'(in_ready), 64'(1));

    // 3: LB / LBU of byte 2 = 0x80
    send(mk(OPC_LOAD, 5'd3, F3_LB), 33'h0_1000_0002);
    tick(); tick();
    check("t3_idle_wait", 64'({rf_we, in_ready}), 64'(0));
    exp_q.push_back({5'd3, 32'hFFFF_FF80});
    mem_return(32'h0080_0000);
    check("t3_lb_we", 64'(rf_we), 64'(1));
    check("t3_lb_data", 64'(rf_wdata), 64'(32'hFFFF_FF80));
    check("t3_flags_hold", 64'({carry_flag, zero_flag}), 64'(2'b11));
    tick();
    send(mk(OPC_LOAD, 5'd3, F3_LBU), 33'h0_1000_0002);
    tick(); tick();
    exp_q.push_back({5'd3, 32'h0000_0080});
    mem_return(32'h0080_0000);
    check("t3_lbu_data", 64'({rf_we, rf_wdata}), 64'({1'b1, 32'h0000_0080}));
    tick();

    // 4: misaligned LW errors without a write; aligned LH of upper half
    send(mk(OPC_LOAD, 5'd4, F3_LW), 33'h0_2000_0001);
    mem_return(32'hCAFE_F00D);
    check("t4_err", 64'({wb_err, rf_we}), 64'(2'b10));
    check("t4_state", 64'(dbg_state), 64'(ST_IDLE));
    tick();
    check("t4_err_pulse", 64'(wb_err), 64'(0));
    check("t4_hold", 64'({rf_waddr, rf_wdata}), 64'({5'd3, 32'h0000_0080}));
    send(mk(OPC_LOAD, 5'd6, F3_LH), 33'h0_2000_0002);
    exp_q.push_back({5'd6, 32'hFFFF_8001});
    mem_return(32'h8001_0000);
    check("t4_lh_data", 64'({rf_we, rf_waddr, rf_wdata}), 64'({1'b1, 5'd6, 32'hFFFF_8001}));
    tick();

    // 5: timeout with no data, then data on the timeout cycle wins
    send(mk(OPC_LOAD, 5'd8, F3_LW), 33'h0_0000_0040);
    repeat (TO - 1) tick();
    check("t5_still_waiting", 64'({dbg_state, wb_err}), 64'({ST_WAIT_MEM, 1'b0}));
    tick();
    check("t5_timeout_err", 64'({wb_err, rf_we}), 64'(2'b10));
    check("t5_timeout_idle", 64'(dbg_state), 64'(ST_IDLE));
    tick();
    send(mk(OPC_LOAD, 5'd9, F3_LW), 33'h0_0000_0080);
    repeat (TO - 1) tick();
    exp_q.push_back({5'd9, 32'hDEAD_BEEF});
    mem_return(32'hDEAD_BEEF);
    check("t5_data_wins", 64'({rf_we, wb_err, rf_wdata}), 64'({2'b10, 32'hDEAD_BEEF}));
    tick();

    // 6: ADDI to x0 updates flags only; JAL leaves flags; SW/BEQ never stall
    send(mk(OPC_OP_IMM, 5'd0, 3'b000), 33'h0_0000_0005);
    check("t6_x0_no_we", 64'(rf_we), 64'(0));
    check("t6_x0_flags", 64'({carry_flag, zero_flag}), 64'(2'b00));
    check("t6_x0_hold", 64'({rf_waddr, rf_wdata}), 64'({5'd9, 32'hDEAD_BEEF}));
    tick();
    exp_q.push_back({5'd1, 32'h0000_0000});
    send(mk(OPC_JAL, 5'd1, 3'b000), 33'h1_0000_0000);
    check("t6_jal_flags", 64'({rf_we, carry_flag, zero_flag}), 64'(3'b100));
    tick();
    send(mk(7'b0100011, 5'd2, 3'b010), 33'h0_0000_0010);
    check("t6_sw", 64'({in_ready, rf_we, dbg_state}), 64'({2'b10, ST_IDLE}));
    send(mk(7'b1100011, 5'd4, 3'b000), 33'h0_0000_0000);
    check("t6_beq", 64'({in_ready, rf_we, dbg_state}), 64'({2'b10, ST_IDLE}));
    tick();

    check("sb_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
